sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the single synchronous data-SRAM port between the instruction-fetch requester and the load/store requester from the memory stage.
- Grants at most one request per cycle, with data priority and a bounded starvation guard for fetch.
- Drives the SRAM enable, write-enable, address and write-data.
- Tracks the single in-flight access and returns read data and completion to the owning requester one cycle later.
- Sits between the pipeline front end, the execute/memory stages and the SRAM macro.

## Interface
- ADDR_W, 32, address width for both requesters and SRAM
- DATA_W, 32, data width; byte strobe width is DATA_W/8
- STARVE_LIMIT, 4, consecutive fetch denials after which fetch wins the next contested cycle (1..15)

- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request valid (read only)
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch read data valid this cycle
- inst_rdata  out  DATA_W  fetch read data
- data_req  in  1  load/store request valid
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  DATA_W/8  store byte strobes
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  load/store accepted this cycle
- data_data_ok  out  1  load data valid, or store complete, this cycle
- data_rdata  out  DATA_W  load read data
- sram_busy  in  1  SRAM cannot accept an access this cycle
- sram_en  out  1  SRAM access enable
- sram_we  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after an enabled read

## Operation
- Grant logic is combinational from the current-cycle requests, sram_busy and the starvation counter.
  - No grant while sram_busy=1 or resetn=0.
  - Data request only: grant data.
  - Fetch request only: grant fetch.
  - Both requesting: grant data unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
- The granted requester's addr_ok is 1 in the same cycle; the other addr_ok is 0.
- On a grant, sram_en=1 and sram_addr is the winner's address.
  - Data grant: sram_we = data_wr ? data_wstrb : 0, and sram_wdata = data_wdata.
  - Fetch grant: sram_we = 0, and sram_wdata = 0.
- With no grant: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
- The starvation counter starve_cnt is 4 bits:
  - increments (saturating at STARVE_LIMIT) on each cycle where inst_req=1 and data is granted;
  - clears on a fetch grant, or when inst_req=0;
  - holds while sram_busy=1 stalls both requesters.
- The response tracker is a register set {resp_valid, resp_owner, resp_wr} loaded every cycle:
  - resp_valid = any grant;
  - resp_owner = data/fetch;
  - resp_wr = data_wr on a data grant.
- Response outputs:
  - inst_data_ok = resp_valid && owner==fetch.
  - data_data_ok = resp_valid && owner==data.
  - inst_rdata and data_rdata pass sram_rdata through.
  - data_rdata is forced to 0 when resp_wr=1.
- A new grant may issue in the same cycle a response is returned. Sustained throughput is one access per cycle.
- Requesters must hold req/addr/data stable until addr_ok. The arbiter does not buffer requests.

## Timing
- Grant to data_ok latency is exactly 1 cycle for every access. Stores also signal completion at +1.
- addr_ok and sram_* are combinational from inputs and state. data_ok and the rdata select are driven from registered state only.
- Reset values while resetn=0: every output is 0.
- Reset state: resp_valid=0, resp_owner=fetch, resp_wr=0, starve_cnt=0.
- Reset asserted with a response in flight: the response is dropped and no data_ok follows after release.
- First cycle after release: a grant is allowed if there are requests and sram_busy=0.
- sram_busy rising in the cycle after a grant does not cancel that cycle's response.

## Test plan
- Reset: resetn low with inst_req=data_req=1 -> all outputs 0. Release; next cycle data granted (sram_addr=data_addr), data_data_ok=1 the cycle after.
- Fetch alone: inst_addr=0x1C000000 held 3 cycles, sram_rdata echoes addr -> inst_addr_ok every cycle; inst_data_ok in cycles 2-4 with rdata 0x1C000000.
- Store: data_wr=1, wstrb=4'b0011, addr=0x100, wdata=0xDEADBEEF -> sram_we=4'b0011, sram_wdata=0xDEADBEEF; data_data_ok=1 next cycle with data_rdata=0.
- Starvation, STARVE_LIMIT=4, both requesting continuously -> grants D,D,D,D,I,D,D,D,D,I...; every grant paired with exactly one matching data_ok one cycle later.
- sram_busy=1 for 3 cycles with both requesting -> no addr_ok, sram_en=0, starve_cnt unchanged. After it drops, grant resumes per counter.
- Reset mid-flight: grant a load, pull resetn low before the next edge -> no data_ok ever appears for that load.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch, load/store and SRAM-macro signals around the shared SRAM port.
// The arbiter connects through the slave modport; the requester/macro side uses master.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_addr_ok;
    logic                  inst_data_ok;
    logic [DATA_W-1:0]     inst_rdata;

    logic                  data_req;
    logic                  data_wr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;

    logic                  sram_busy;
    logic                  sram_en;
    logic [DATA_W/8-1:0]   sram_we;
    logic [ADDR_W-1:0]     sram_addr;
    logic [DATA_W-1:0]     sram_wdata;
    logic [DATA_W-1:0]     sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  sram_busy, sram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output sram_busy, sram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and load/store,
// data first with a bounded starvation guard for fetch; one access in flight, response at +1.
module sram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_port_arbiter_if.slave   bus
);
    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_nxt;
    logic       starve_hit;
    logic       can_grant;
    logic       grant_data;
    logic       grant_inst;

    logic       resp_valid;
    logic       resp_wr;
    owner_e     resp_owner;

    // Contested cycles go to data unless fetch has already lost STARVE_LIMIT times in a row.
    always_comb begin
        starve_hit = (starve_cnt == 4'(STARVE_LIMIT));
        can_grant  = resetn & ~bus.sram_busy;
        grant_data = can_grant & bus.data_req & ~(bus.inst_req & starve_hit);
        grant_inst = can_grant & bus.inst_req & (~bus.data_req | starve_hit);
    end

    always_comb begin
        bus.inst_addr_ok = grant_inst;
        bus.data_addr_ok = grant_data;
        bus.sram_en      = 1'b0;
        bus.sram_we      = '0;
        bus.sram_addr    = '0;
        bus.sram_wdata   = '0;
        if (grant_data) begin
            bus.sram_en    = 1'b1;
            bus.sram_we    = bus.data_wr ? bus.data_wstrb : '0;
            bus.sram_addr  = bus.data_addr;
            bus.sram_wdata = bus.data_wdata;
        end else if (grant_inst) begin
            bus.sram_en    = 1'b1;
            bus.sram_addr  = bus.inst_addr;
        end
    end

    // A busy SRAM freezes the count so the guard survives stalls.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!bus.sram_busy) begin
            if (!bus.inst_req || grant_inst) begin
                starve_cnt_nxt = 4'd0;
            end else if (grant_data && !starve_hit) begin
                starve_cnt_nxt = starve_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid <= 1'b0;
            resp_owner <= OWNER_FETCH;
            resp_wr    <= 1'b0;
        end else begin
            resp_valid <= grant_data | grant_inst;
            resp_owner <= grant_data ? OWNER_DATA : OWNER_FETCH;
            resp_wr    <= grant_data & bus.data_wr;
        end
    end

    // Read data is a pass-through of the macro; stores return zero so nothing stale leaks out.
    always_comb begin
        bus.inst_data_ok = resp_valid & (resp_owner == OWNER_FETCH);
        bus.data_data_ok = resp_valid & (resp_owner == OWNER_DATA);
        bus.inst_rdata   = resetn ? bus.sram_rdata : '0;
        bus.data_rdata   = (resetn && !resp_wr) ? bus.sram_rdata : '0;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a cycle-level behavioural model.
module tb_sram_port_arbiter;
    localparam int LIMIT = 4;

    logic clk;
    logic resetn;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // stimulus for the next cycle
    bit          r_rstn, r_ireq, r_dreq, r_dwr, r_busy;
    logic [31:0] r_iaddr, r_daddr, r_wdata, r_rdata;
    logic [3:0]  r_strb;

    // model state: fetch-denial streak and the access awaiting its response
    int m_starve = 0;
    bit m_pv = 0;
    bit m_po = 0;   // 1 = data owns the pending response
    bit m_pw = 0;
    bit g_i, g_d;   // expected grants of the last cycle

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_cycle(input bit drop_rst);
        bit ok, ed, ei;
        logic [3:0]  e_we;
        logic [31:0] e_addr, e_wdata;
        @(posedge clk);
        #1;
        resetn          = r_rstn;
        bus.inst_req    = r_ireq;
        bus.inst_addr   = r_iaddr;
        bus.data_req    = r_dreq;
        bus.data_wr     = r_dwr;
        bus.data_wstrb  = r_strb;
        bus.data_addr   = r_daddr;
        bus.data_wdata  = r_wdata;
        bus.sram_busy   = r_busy;
        bus.sram_rdata  = r_rdata;
        if (!r_rstn) begin
            m_starve = 0; m_pv = 0; m_po = 0; m_pw = 0;
        end
        ok = r_rstn && !r_busy;
        ed = ok && r_dreq && !(r_ireq && m_starve == LIMIT);
        ei = ok && r_ireq && !ed;
        e_we    = (ed && r_dwr) ? r_strb : 4'h0;
        e_addr  = ed ? r_daddr : (ei ? r_iaddr : 32'h0);
        e_wdata = ed ? r_wdata : 32'h0;
        #3;
        chk("inst_addr_ok", 64'(bus.inst_addr_ok), 64'(ei));
        chk("data_addr_ok", 64'(bus.data_addr_ok), 64'(ed));
        chk("sram_en",      64'(bus.sram_en),      64'(ed || ei));
        chk("sram_we",      64'(bus.sram_we),      64'(e_we));
        chk("sram_addr",    64'(bus.sram_addr),    64'(e_addr));
        chk("sram_wdata",   64'(bus.sram_wdata),   64'(e_wdata));
        chk("inst_data_ok", 64'(bus.inst_data_ok), 64'(m_pv && !m_po));
        chk("data_data_ok", 64'(bus.data_data_ok), 64'(m_pv && m_po));
        chk("inst_rdata",   64'(bus.inst_rdata),   64'(r_rstn ? r_rdata : 32'h0));
        chk("data_rdata",   64'(bus.data_rdata),   64'((r_rstn && !m_pw) ? r_rdata : 32'h0));
        g_i = ei;
        g_d = ed;
        if (drop_rst) resetn = 1'b0;
        if (!resetn) begin
            m_starve = 0; m_pv = 0; m_po = 0; m_pw = 0;
        end else begin
            m_pv = ed || ei;
            m_po = ed;
            m_pw = ed && r_dwr;
            if (!r_busy) begin
                if (!r_ireq || ei) m_starve = 0;
                else if (ed) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            end
        end
    endtask

    task automatic idle();
        r_ireq = 0; r_dreq = 0; r_dwr = 0; r_busy = 0;
        r_rdata = $urandom;
    endtask

    initial begin
        logic [9:0] pattern;
        int         late_ok;
        resetn = 1'b0;
        r_rstn = 0; r_busy = 0; r_rdata = 32'h0;
        r_ireq = 1; r_iaddr = 32'h0000_0040;
        r_dreq = 1; r_dwr = 0; r_strb = 4'hF; r_daddr = 32'h0000_0200; r_wdata = 32'h1234_5678;

        // reset with both requesting, then release: data wins first
        repeat (3) begin
            r_rdata = $urandom;
            run_cycle(0);
        end
        r_rstn = 1;
        run_cycle(0);
        chk("rel_sram_addr", 64'(bus.sram_addr), 64'h200);
        idle();
        run_cycle(0);
        chk("rel_data_ok", 64'(bus.data_data_ok), 64'h1);

        // fetch alone for three cycles, macro echoing the address
        idle();
        r_ireq = 1; r_iaddr = 32'h1C00_0000; r_rdata = 32'h1C00_0000;
        repeat (3) run_cycle(0);
        idle();
        r_rdata = 32'h1C00_0000;
        run_cycle(0);
        chk("fetch_last_ok", 64'(bus.inst_data_ok), 64'h1);

        // half-word store
        idle();
        r_dreq = 1; r_dwr = 1; r_strb = 4'b0011; r_daddr = 32'h100; r_wdata = 32'hDEAD_BEEF;
        run_cycle(0);
        chk("store_we", 64'(bus.sram_we), 64'h3);
        idle();
        r_rdata = 32'hA5A5_A5A5;
        run_cycle(0);
        chk("store_rdata", 64'(bus.data_rdata), 64'h0);

        // continuous contention: D,D,D,D,I repeating
        r_ireq = 1; r_iaddr = 32'h1C00_0010;
        r_dreq = 1; r_dwr = 0; r_daddr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            r_rdata = $urandom;
            run_cycle(0);
            pattern[i] = bus.data_addr_ok;
        end
        chk("starve_pattern", 64'(pattern), 64'(10'b0111101111));
        idle();
        run_cycle(0);

        // stall in the middle of a denial streak
        r_ireq = 1; r_dreq = 1; r_dwr = 0;
        repeat (2) run_cycle(0);
        r_busy = 1;
        repeat (3) begin
            run_cycle(0);
            chk("busy_no_grant", 64'(bus.sram_en), 64'h0);
        end
        r_busy = 0;
        repeat (3) run_cycle(0);
        chk("busy_resume_i", 64'(bus.inst_addr_ok), 64'h1);
        idle();
        run_cycle(0);

        // load granted, reset pulled before the capturing edge
        r_dreq = 1; r_dwr = 0; r_daddr = 32'h400;
        run_cycle(1);
        idle();
        r_rstn = 0;
        late_ok = 0;
        repeat (2) begin
            run_cycle(0);
            late_ok += int'(bus.data_data_ok);
        end
        r_rstn = 1;
        repeat (2) begin
            run_cycle(0);
            late_ok += int'(bus.data_data_ok);
        end
        chk("midflight_dropped", 64'(late_ok), 64'h0);

        // randomized traffic; requesters hold until accepted
        g_i = 0; g_d = 0;
        for (int c = 0; c < 600; c++) begin
            if (!(r_ireq && !g_i)) begin
                r_ireq  = ($urandom_range(99) < 60);
                r_iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!(r_dreq && !g_d)) begin
                r_dreq  = ($urandom_range(99) < 60);
                r_dwr   = $urandom_range(1);
                r_strb  = 4'($urandom);
                r_daddr = $urandom;
                r_wdata = $urandom;
            end
            r_busy  = ($urandom_range(99) < 20);
            r_rstn  = ($urandom_range(99) >= 2);
            r_rdata = $urandom;
            run_cycle(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
